// File: rtl/gpu_def.sv
// rtl/gpu_def.sv - shared types and constants for the CPU-to-VRAM pixel FIFO
package gpu_def;

  typedef enum logic {
    CVF_IDLE,
    CVF_LOAD
  } cvFifoState_t;

  localparam int CV_PIXCNT_W = 20;
  localparam int CV_WORDS_W  = 19;

endpackage

// File: rtl/gpu_cv_bank.sv
// rtl/gpu_cv_bank.sv - single-bank pixel FIFO with registered pop data
// An empty-bank pop is ignored: pointers, level and output data all hold.
module gpu_cv_bank #(
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [PW-1:0]              i_pushData,
  input  logic                       i_pop,
  output logic [PW-1:0]              o_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_canRead,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          pushEff;
  logic          popEff;

  // Clear takes priority; the top also gates these, but keep the bank self-consistent.
  assign pushEff = i_push & ~i_clear;
  assign popEff  = i_pop & ~i_clear & (level != '0);

  always_ff @(posedge i_clk) begin
    if (pushEff) begin
      mem[wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      level  <= '0;
      o_data <= '0;
    end else if (i_clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushEff) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (popEff) begin
        rdPtr  <= rdPtr + AW'(1);
        o_data <= mem[rdPtr];
      end
      case ({pushEff, popEff})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_level   = level;
  assign o_canRead = (level != '0);
  assign o_full    = (level == LW'(DEPTH));

endmodule

// File: rtl/gpu_cv_pair_fifo.sv
// rtl/gpu_cv_pair_fifo.sv - splits GP0 words into L/M pixel banks for the VRAM copy sequencer
// Optional stall/empty-pop error checking is built when GPU_CVFIFO_ERRCHK_EN is defined.
module gpu_cv_pair_fifo
  import gpu_def::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_start,
  input  logic [CV_PIXCNT_W-1:0]     i_pixelCount,
  input  logic                       i_wordValid,
  input  logic [31:0]                i_word,
  output logic                       o_wordReady,
  input  logic                       i_readL,
  input  logic                       i_readM,
  output logic [PW-1:0]              o_pixelL,
  output logic [PW-1:0]              o_pixelM,
  output logic                       o_canReadL,
  output logic                       o_canReadM,
  output logic                       o_xferDone,
  output logic [$clog2(DEPTH):0]     o_levelL,
  output logic [$clog2(DEPTH):0]     o_levelM,
  output logic                       o_error
);

  cvFifoState_t            state;
  cvFifoState_t            stateNext;
  logic [CV_WORDS_W-1:0]   wordsLeft;
  logic [CV_WORDS_W-1:0]   wordsInit;
  logic                    fullL;
  logic                    fullM;
  logic                    accept;
  logic                    lastWord;
  logic                    popL;
  logic                    popM;

  // A count of 524288 must round to 262144 without losing the top bit.
  assign wordsInit = CV_WORDS_W'((i_pixelCount + CV_PIXCNT_W'(1)) >> 1);

  assign o_wordReady = (state == CVF_LOAD) & ~fullL & ~fullM;
  assign accept      = o_wordReady & i_wordValid & ~i_start;
  assign lastWord    = accept & (wordsLeft == CV_WORDS_W'(1));
  assign popL        = i_readL & ~i_start;
  assign popM        = i_readM & ~i_start;

  always_comb begin
    stateNext = state;
    case (state)
      CVF_IDLE: if (i_start) stateNext = CVF_LOAD;
      CVF_LOAD: begin
        if (i_start) stateNext = CVF_LOAD;
        else if (lastWord) stateNext = CVF_IDLE;
      end
      default: stateNext = CVF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= CVF_IDLE;
      wordsLeft  <= '0;
      o_xferDone <= 1'b0;
    end else begin
      state <= stateNext;
      if (i_start) begin
        wordsLeft  <= wordsInit;
        o_xferDone <= 1'b0;
      end else if (accept) begin
        wordsLeft <= wordsLeft - CV_WORDS_W'(1);
        if (lastWord) o_xferDone <= 1'b1;
      end
    end
  end

  gpu_cv_bank #(.DEPTH(DEPTH), .PW(PW)) u_bankL (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_clear    (i_start),
    .i_push     (accept),
    .i_pushData (i_word[15:0]),
    .i_pop      (popL),
    .o_data     (o_pixelL),
    .o_level    (o_levelL),
    .o_canRead  (o_canReadL),
    .o_full     (fullL)
  );

  gpu_cv_bank #(.DEPTH(DEPTH), .PW(PW)) u_bankM (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_clear    (i_start),
    .i_push     (accept),
    .i_pushData (i_word[31:16]),
    .i_pop      (popM),
    .o_data     (o_pixelM),
    .o_level    (o_levelM),
    .o_canRead  (o_canReadM),
    .o_full     (fullM)
  );

`ifdef GPU_CVFIFO_ERRCHK_EN
  logic [9:0] stallCnt;
  logic       stalled;
  logic       emptyPop;

  assign stalled  = (state == CVF_LOAD) & i_wordValid & (fullL | fullM);
  assign emptyPop = (popL & ~o_canReadL) | (popM & ~o_canReadM);

  // Saturating count of consecutive stalled cycles; the 1024th one trips the flag.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      stallCnt <= '0;
      o_error  <= 1'b0;
    end else if (i_start) begin
      stallCnt <= '0;
      o_error  <= 1'b0;
    end else begin
      if (!stalled) stallCnt <= '0;
      else if (stallCnt != 10'h3FF) stallCnt <= stallCnt + 10'd1;
      if (emptyPop || (stalled && stallCnt == 10'h3FF)) o_error <= 1'b1;
    end
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_cv_pair_fifo.sv
// tb/tb_gpu_cv_pair_fifo.sv - directed self-checking bench for gpu_cv_pair_fifo
module tb_gpu_cv_pair_fifo;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_start = 1'b0;
  logic [19:0] i_pixelCount = '0;
  logic        i_wordValid = 1'b0;
  logic [31:0] i_word = '0;
  logic        o_wordReady;
  logic        i_readL = 1'b0;
  logic        i_readM = 1'b0;
  logic [15:0] o_pixelL;
  logic [15:0] o_pixelM;
  logic        o_canReadL;
  logic        o_canReadM;
  logic        o_xferDone;
  logic [3:0]  o_levelL;
  logic [3:0]  o_levelM;
  logic        o_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  gpu_cv_pair_fifo #(.DEPTH(8), .PW(16)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_start      (i_start),
    .i_pixelCount (i_pixelCount),
    .i_wordValid  (i_wordValid),
    .i_word       (i_word),
    .o_wordReady  (o_wordReady),
    .i_readL      (i_readL),
    .i_readM      (i_readM),
    .o_pixelL     (o_pixelL),
    .o_pixelM     (o_pixelM),
    .o_canReadL   (o_canReadL),
    .o_canReadM   (o_canReadM),
    .o_xferDone   (o_xferDone),
    .o_levelL     (o_levelL),
    .o_levelM     (o_levelM),
    .o_error      (o_error)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doStart(input logic [19:0] cnt);
    i_start = 1'b1;
    i_pixelCount = cnt;
    tick();
    i_start = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w);
    i_wordValid = 1'b1;
    i_word = w;
    tick();
    i_wordValid = 1'b0;
  endtask

  task automatic popBanks(input logic l, input logic m);
    i_readL = l;
    i_readM = m;
    tick();
    i_readL = 1'b0;
    i_readM = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({o_wordReady, o_xferDone, o_canReadL, o_canReadM, o_error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {o_wordReady, o_xferDone, o_canReadL, o_canReadM, o_error});
    end
    vectors++;
    if ({o_levelL, o_levelM, o_pixelL, o_pixelM} !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0", {o_levelL, o_levelM, o_pixelL, o_pixelM});
    end
    @(negedge i_clk);
    i_nrst = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    logic [15:0] exp [6];
    exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    doStart(20'd6);
    vectors++;
    if (o_wordReady !== 1'b1 || o_xferDone !== 1'b0) begin
      miscompares++;
      $display("FAIL aligned_start ready/done got %b%b want 10", o_wordReady, o_xferDone);
    end
    pushWord(32'h0002_0001);
    pushWord(32'h0004_0003);
    vectors++;
    if (o_xferDone !== 1'b0) begin
      miscompares++;
      $display("FAIL aligned_early_done got %b want 0", o_xferDone);
    end
    pushWord(32'h0006_0005);
    vectors++;
    if (o_xferDone !== 1'b1 || o_wordReady !== 1'b0 || o_levelL !== 4'd3 || o_levelM !== 4'd3) begin
      miscompares++;
      $display("FAIL aligned_done got done=%b rdy=%b lL=%0d lM=%0d want 1 0 3 3", o_xferDone, o_wordReady, o_levelL, o_levelM);
    end
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        popBanks(1'b1, 1'b0);
        vectors++;
        if (o_pixelL !== exp[i]) begin
          miscompares++;
          $display("FAIL aligned_popL[%0d] got %h want %h", i, o_pixelL, exp[i]);
        end
      end else begin
        popBanks(1'b0, 1'b1);
        vectors++;
        if (o_pixelM !== exp[i]) begin
          miscompares++;
          $display("FAIL aligned_popM[%0d] got %h want %h", i, o_pixelM, exp[i]);
        end
      end
    end
  endtask

  task automatic test_odd();
    doStart(20'd3);
    pushWord(32'h000B_000A);
    pushWord(32'h000D_000C);
    i_wordValid = 1'b1;
    i_word = 32'h000F_000E;
    #1;
    vectors++;
    if (o_wordReady !== 1'b0 || o_xferDone !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_refuse got rdy=%b done=%b want 0 1", o_wordReady, o_xferDone);
    end
    tick();
    i_wordValid = 1'b0;
    vectors++;
    if (o_levelL !== 4'd2 || o_levelM !== 4'd2) begin
      miscompares++;
      $display("FAIL odd_levels got %0d %0d want 2 2", o_levelL, o_levelM);
    end
    popBanks(1'b1, 1'b0);
    popBanks(1'b0, 1'b1);
    popBanks(1'b1, 1'b0);
    vectors++;
    if (o_pixelL !== 16'h000C || o_pixelM !== 16'h000B || o_levelM !== 4'd1 || o_levelL !== 4'd0) begin
      miscompares++;
      $display("FAIL odd_drain got pL=%h pM=%h lL=%0d lM=%0d want 000c 000b 0 1", o_pixelL, o_pixelM, o_levelL, o_levelM);
    end
  endtask

  task automatic test_full();
    doStart(20'd32);
    for (int i = 0; i < 8; i++) begin
      pushWord({16'h0100 + 16'(i), 16'h0200 + 16'(i)});
    end
    vectors++;
    if (o_wordReady !== 1'b0 || o_levelL !== 4'd8 || o_levelM !== 4'd8) begin
      miscompares++;
      $display("FAIL full_stop got rdy=%b lL=%0d lM=%0d want 0 8 8", o_wordReady, o_levelL, o_levelM);
    end
    popBanks(1'b1, 1'b0);
    vectors++;
    if (o_wordReady !== 1'b0 || o_pixelL !== 16'h0200 || o_levelL !== 4'd7) begin
      miscompares++;
      $display("FAIL full_popL got rdy=%b pL=%h lL=%0d want 0 0200 7", o_wordReady, o_pixelL, o_levelL);
    end
    popBanks(1'b0, 1'b1);
    vectors++;
    if (o_wordReady !== 1'b1 || o_pixelM !== 16'h0100) begin
      miscompares++;
      $display("FAIL full_popM got rdy=%b pM=%h want 1 0100", o_wordReady, o_pixelM);
    end
  endtask

  task automatic test_empty_pop();
    doStart(20'd2);
    popBanks(1'b0, 1'b1);
    vectors++;
    if (o_pixelM !== 16'h0100 || o_levelM !== 4'd0 || o_canReadM !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pop got pM=%h lM=%0d can=%b want 0100 0 0", o_pixelM, o_levelM, o_canReadM);
    end
`ifdef GPU_CVFIFO_ERRCHK_EN
    vectors++;
    if (o_error !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_pop_err got %b want 1", o_error);
    end
`else
    vectors++;
    if (o_error !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pop_err got %b want 0", o_error);
    end
`endif
  endtask

  task automatic test_back_to_back();
    doStart(20'd24);
    for (int k = 0; k < 4; k++) pushWord({16'h0B00 + 16'(k), 16'h0A00 + 16'(k)});
    for (int j = 0; j < 8; j++) begin
      i_wordValid = 1'b1;
      i_word = {16'h0B00 + 16'(j + 4), 16'h0A00 + 16'(j + 4)};
      i_readL = 1'b1;
      i_readM = 1'b1;
      tick();
      vectors++;
      if (o_levelL !== 4'd4 || o_levelM !== 4'd4 || o_pixelL !== 16'h0A00 + 16'(j) || o_pixelM !== 16'h0B00 + 16'(j)) begin
        miscompares++;
        $display("FAIL b2b[%0d] got lL=%0d lM=%0d pL=%h pM=%h want 4 4 %h %h", j, o_levelL, o_levelM, o_pixelL, o_pixelM,
                 16'h0A00 + 16'(j), 16'h0B00 + 16'(j));
      end
    end
    i_wordValid = 1'b0;
    vectors++;
    if (o_xferDone !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done got %b want 1", o_xferDone);
    end
    for (int j = 8; j < 12; j++) begin
      popBanks(1'b1, 1'b1);
      vectors++;
      if (o_pixelL !== 16'h0A00 + 16'(j) || o_pixelM !== 16'h0B00 + 16'(j)) begin
        miscompares++;
        $display("FAIL b2b_drain[%0d] got %h %h want %h %h", j, o_pixelL, o_pixelM, 16'h0A00 + 16'(j), 16'h0B00 + 16'(j));
      end
    end
    vectors++;
    if (o_levelL !== 4'd0 || o_levelM !== 4'd0) begin
      miscompares++;
      $display("FAIL b2b_empty got %0d %0d want 0 0", o_levelL, o_levelM);
    end
  endtask

  task automatic test_restart();
    doStart(20'd40);
    for (int k = 0; k < 5; k++) pushWord(32'h5000_0000 + 32'(k));
    vectors++;
    if (o_levelL !== 4'd5) begin
      miscompares++;
      $display("FAIL restart_pre got %0d want 5", o_levelL);
    end
    i_start = 1'b1;
    i_pixelCount = 20'd4;
    i_wordValid = 1'b1;
    i_word = 32'hDEAD_BEEF;
    tick();
    i_start = 1'b0;
    i_wordValid = 1'b0;
    vectors++;
    if (o_levelL !== 4'd0 || o_levelM !== 4'd0 || o_xferDone !== 1'b0 || o_wordReady !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear got lL=%0d lM=%0d done=%b rdy=%b want 0 0 0 1", o_levelL, o_levelM, o_xferDone, o_wordReady);
    end
    pushWord(32'h1111_2222);
    vectors++;
    if (o_xferDone !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_mid got %b want 0", o_xferDone);
    end
    pushWord(32'h3333_4444);
    vectors++;
    if (o_xferDone !== 1'b1 || o_levelL !== 4'd2) begin
      miscompares++;
      $display("FAIL restart_count got done=%b lL=%0d want 1 2", o_xferDone, o_levelL);
    end
    popBanks(1'b1, 1'b1);
    vectors++;
    if (o_pixelL !== 16'h2222 || o_pixelM !== 16'h1111) begin
      miscompares++;
      $display("FAIL restart_data got %h %h want 2222 1111", o_pixelL, o_pixelM);
    end
  endtask

  task automatic test_reset_mid();
    doStart(20'd10);
    pushWord(32'h0077_0066);
    pushWord(32'h0099_0088);
    popBanks(1'b1, 1'b0);
    #2;
    i_nrst = 1'b0;
    #1;
    vectors++;
    if (o_levelL !== 4'd0 || o_levelM !== 4'd0 || o_wordReady !== 1'b0 || o_pixelL !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid got lL=%0d lM=%0d rdy=%b pL=%h want 0 0 0 0000", o_levelL, o_levelM, o_wordReady, o_pixelL);
    end
    @(negedge i_clk);
    i_nrst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_odd();
    test_full();
    test_empty_pop();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
